// File: rtl/output_stream_tagger_pkg.sv
// Shared types and helpers for the output stream tagger: job configuration,
// traversal order and FSM state encodings.
package output_stream_tagger_pkg;

  typedef struct packed {
    int data_width;
    int feature_map_width;
    int feature_map_height;
    int output_nb_channels;
    int fifo_depth;
  } config_t;

  localparam config_t DEFAULT_CFG = '{16, 128, 128, 64, 4};

  typedef enum logic {
    ORDER_CH_FIRST = 1'b0,
    ORDER_X_FIRST  = 1'b1
  } order_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Number of result words in one complete feature map.
  function automatic int total_words(config_t cfg);
    return cfg.feature_map_width * cfg.feature_map_height * cfg.output_nb_channels;
  endfunction

endpackage

// File: rtl/output_stream_tagger_fifo.sv
// Synchronous FIFO with registered storage; pointers carry one wrap bit so
// full and empty are distinguished without an occupancy counter.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Empty reads return zero so a freshly reset FIFO never exposes stale storage.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every variable gets its default before any branch, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/output_stream_tagger.sv
// Buffers result words from the PE array, tags each with its (x, y, ch)
// coordinate and streams them out under valid/ready with a start/done job lifecycle.
module output_stream_tagger
  import output_stream_tagger_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                                  clk,
  input  logic                                  arst_n,
  input  logic                                  start,
  input  logic                                  order_sel,
  output logic                                  running,
  output logic                                  done,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [DATA_WIDTH-1:0]                 output_data,
  output logic                                  output_valid,
  input  logic                                  output_ready,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch
);

  localparam config_t CFG = '{DATA_WIDTH, FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT,
                              OUTPUT_NB_CHANNELS, FIFO_DEPTH};
  localparam int TOTAL = total_words(CFG);
  localparam int XW    = $clog2(CFG.feature_map_width);
  localparam int YW    = $clog2(CFG.feature_map_height);
  localparam int CHW   = $clog2(CFG.output_nb_channels);
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [XW-1:0]    X_MAX      = XW'(CFG.feature_map_width - 1);
  localparam logic [YW-1:0]    Y_MAX      = YW'(CFG.feature_map_height - 1);
  localparam logic [CHW-1:0]   CH_MAX     = CHW'(CFG.output_nb_channels - 1);
  localparam logic [CNT_W-1:0] TOTAL_CNT  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TOTAL - 1);

  state_e             state_q, state_d;
  order_e             order_q, order_d;
  logic [CNT_W-1:0]   accepted_q, accepted_d;
  logic [CNT_W-1:0]   emitted_q, emitted_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic               done_q, done_d;

  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic               x_wrap, y_wrap, ch_wrap;

  assign running      = (state_q == ST_RUN);
  assign done         = done_q;
  assign in_ready     = running && !fifo_full && (accepted_q != TOTAL_CNT);
  assign output_valid = running && !fifo_empty;
  assign push         = in_valid && in_ready;
  assign pop          = output_valid && output_ready;
  assign output_x     = x_q;
  assign output_y     = y_q;
  assign output_ch    = ch_q;

  assign x_wrap  = (x_q == X_MAX);
  assign y_wrap  = (y_q == Y_MAX);
  assign ch_wrap = (ch_q == CH_MAX);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .arst_n(arst_n),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (output_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    order_d    = order_q;
    accepted_d = accepted_q;
    emitted_d  = emitted_q;
    x_d        = x_q;
    y_d        = y_q;
    ch_d       = ch_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          order_d    = order_e'(order_sel);
          accepted_d = '0;
          emitted_d  = '0;
          x_d        = '0;
          y_d        = '0;
          ch_d       = '0;
        end
      end

      ST_RUN: begin
        if (push) accepted_d = accepted_q + 1'b1;
        if (pop) begin
          emitted_d = emitted_q + 1'b1;
          // Coordinates follow the word at the FIFO head, so they step only on a pop.
          if (order_q == ORDER_CH_FIRST) begin
            ch_d = ch_wrap ? '0 : ch_q + 1'b1;
            if (ch_wrap) begin
              x_d = x_wrap ? '0 : x_q + 1'b1;
              if (x_wrap) y_d = y_wrap ? '0 : y_q + 1'b1;
            end
          end else begin
            x_d = x_wrap ? '0 : x_q + 1'b1;
            if (x_wrap) begin
              y_d = y_wrap ? '0 : y_q + 1'b1;
              if (y_wrap) ch_d = ch_wrap ? '0 : ch_q + 1'b1;
            end
          end
          if (emitted_q == LAST_CNT) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            accepted_d = '0;
            emitted_d  = '0;
            x_d        = '0;
            y_d        = '0;
            ch_d       = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      order_q    <= ORDER_CH_FIRST;
      accepted_q <= '0;
      emitted_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      ch_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      order_q    <= order_d;
      accepted_q <= accepted_d;
      emitted_q  <= emitted_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ch_q       <= ch_d;
      done_q     <= done_d;
    end
  end

endmodule
